// File: rtl/uart_pkg.sv
// Shared UART constants: ASCII control bytes and the default receive-buffer depth.
package uart_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam int UART_BUF_DEPTH_LOG2_DEFAULT = 4;

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO of 2**DEPTH_LOG2 entries. The caller must only push when
// not full (or when popping in the same cycle) and only pop when not empty.
module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            wr_data,
  output logic [7:0]            rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  // NOTE: the storage array has no reset; valid data is defined solely by
  // the pointers and count, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: one push per receiver frame, LF line counting, sticky overflow.
// Build option: define UART_RX_BUF_CR_DROP_EN to discard received CR (8'h0D) bytes.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_BUF_DEPTH_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic [DEPTH_LOG2:0] count,
  output logic [DEPTH_LOG2:0] line_cnt,
  output logic                line_avail,
  output logic                overflow,
  input  logic                clr_ovf
);

  logic ready_q;
  logic push_req;
  logic cr_drop;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic drop;
  logic lf_in;
  logic lf_out;

  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= rx_ready;
  end

  // rx_ready is a level that stays high until the next start bit; only its rising edge is a frame.
  assign push_req = rx_ready & ~ready_q;

`ifdef UART_RX_BUF_CR_DROP_EN
  assign cr_drop = (rx_data == ASCII_CR);
`else
  assign cr_drop = 1'b0;
`endif

  assign pop  = rd_en & ~fifo_empty;
  assign push = push_req & ~cr_drop & (~fifo_full | pop);
  assign drop = push_req & ~cr_drop & fifo_full & ~pop;

  uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (rx_data),
    .rd_data (rd_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_valid = ~fifo_empty;
  assign lf_in    = push & (rx_data == ASCII_LF);
  assign lf_out   = pop & (rd_data == ASCII_LF);

  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      unique case ({lf_in, lf_out})
        2'b10:   line_cnt <= line_cnt + 1'b1;
        2'b01:   line_cnt <= line_cnt - 1'b1;
        default: line_cnt <= line_cnt;
      endcase
      // A drop coinciding with clr_ovf must still leave the flag set.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign line_avail = (line_cnt != '0);

endmodule
